seq_detector_param: RTL



---
 rtl/seq_detector_param_if.sv | 17 +
 rtl/seq_detector_param.sv | 45 ++++
 2 files changed

// File: rtl/seq_detector_param_if.sv
// seq_detector_param_if: serial stream bus (clr, x_valid, x, pattern, pat_len, overlap in; z, match_cnt out)
interface seq_detector_param_if #(
  parameter int PAT_W = 8,
  parameter int LEN_W = $clog2(PAT_W + 1),
  parameter int CNT_W = 8
);
  logic             clr;
  logic             x_valid;
  logic             x;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] pat_len;
  logic             overlap;
  logic             z;
  logic [CNT_W-1:0] match_cnt;
  modport master (output clr, x_valid, x, pattern, pat_len, overlap, input z, match_cnt);
  modport slave  (input clr, x_valid, x, pattern, pat_len, overlap, output z, match_cnt);
endinterface

// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-pattern serial detector; clk, reset (sync, active-high), bus.slave (clr/x_valid/x/pattern/pat_len/overlap in, z/match_cnt out); SEQ_DET_CNT_EN enables the saturating match_cnt, otherwise it is tied to 0
module seq_detector_param #(
  parameter int PAT_W = 8,
  parameter int LEN_W = $clog2(PAT_W + 1),
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic reset,
  seq_detector_param_if.slave bus
);
  logic [PAT_W-1:0] hist_q, hist_d, hist_n, mask;
  logic [LEN_W-1:0] fill_q, fill_d, fill_n;
  logic             z_q, z_d, len_ok, match;
  always_comb begin
    hist_n = {hist_q[PAT_W-2:0], bus.x};
    fill_n = fill_q == LEN_W'(PAT_W) ? fill_q : fill_q + 1'b1;
    mask   = ~({PAT_W{1'b1}} << bus.pat_len);
    len_ok = bus.pat_len != '0 && bus.pat_len <= LEN_W'(PAT_W);
    match  = bus.x_valid && !bus.clr && len_ok && fill_n >= bus.pat_len &&
             ((hist_n ^ bus.pattern) & mask) == '0;
    hist_d = bus.clr ? '0 : bus.x_valid ? hist_n : hist_q;
    fill_d = bus.clr || (match && !bus.overlap) ? '0 : bus.x_valid ? fill_n : fill_q;
    z_d    = match;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
      z_q    <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      z_q    <= z_d;
    end
  end
  assign bus.z = z_q;
`ifdef SEQ_DET_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = match && cnt_q != '1 ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
  assign bus.match_cnt = cnt_q;
`else
  assign bus.match_cnt = '0;
`endif
endmodule
